// File: rtl/soc_system_pll_reset_seq.sv
`default_nettype none
// soc_system_pll_reset_seq - PLL lock synchronizer and fabric reset sequencer (rev 1.0).
// Retries the PLL on lock timeout and counts lock losses and timeouts.
module soc_system_pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_DELAY       = 16,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_count,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [2:0]       seq_state
);

  localparam int MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD    = (LOCK_STABLE_CYCLES > RELEASE_DELAY) ? LOCK_STABLE_CYCLES : RELEASE_DELAY;
  localparam int MAX_DWELL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int DWELL_W   = $clog2(MAX_DWELL + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DWELL_W-1:0] dwell;
  logic               sync1;
  logic               locked_s;
  logic               loss_inc;
  logic               tmo_inc;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (cnt != '1)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= S_PLL_RST;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= (state_nxt != state) ? '0 : dwell + DWELL_W'(1);
    end
  end

  always_comb begin
    state_nxt = S_PLL_RST;
    loss_inc  = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      S_PLL_RST: begin
        state_nxt = (dwell == DWELL_W'(PLL_RST_CYCLES - 1)) ? S_WAIT_LOCK : S_PLL_RST;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
        end else if (dwell == DWELL_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_PLL_RST;
          tmo_inc   = 1'b1;
        end else begin
          state_nxt = S_WAIT_LOCK;
        end
      end
      S_STABLE: begin
        // A dropout here only restarts the lock wait; it is not a loss event.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (dwell == DWELL_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_nxt = S_RELEASE;
        end else begin
          state_nxt = S_STABLE;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          state_nxt = S_PLL_RST;
          loss_inc  = 1'b1;
        end else if (dwell == DWELL_W'(RELEASE_DELAY - 1)) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_RELEASE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_PLL_RST;
          loss_inc  = 1'b1;
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as seq_state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst       <= 1'b1;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      pll_rst       <= (state_nxt == S_PLL_RST);
      sys_reset     <= (state_nxt != S_RUN);
      ready         <= (state_nxt == S_RUN);
      loss_count    <= next_count(loss_count, loss_inc, clear_count);
      timeout_count <= next_count(timeout_count, tmo_inc, clear_count);
    end
  end

  assign seq_state = state;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pll_reset_seq.sv
`default_nettype none
// tb_soc_system_pll_reset_seq - directed scenarios plus randomized lock behaviour
// checked every cycle against a phase/elapsed-time model of the sequencer.
module tb_soc_system_pll_reset_seq;

  localparam int P_RST = 4;
  localparam int TMO   = 32;
  localparam int STAB  = 8;
  localparam int REL   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          refclk      = 1'b0;
  logic          rst         = 1'b1;
  logic          pll_locked  = 1'b0;
  logic          clear_count = 1'b0;
  logic          pll_rst;
  logic          sys_reset;
  logic          ready;
  logic [CW-1:0] loss_count;
  logic [CW-1:0] timeout_count;
  logic [2:0]    seq_state;

  int checks = 0;
  int fails  = 0;

  soc_system_pll_reset_seq #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STAB),
    .RELEASE_DELAY       (REL),
    .CNT_W               (CW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clear_count   (clear_count),
    .pll_rst       (pll_rst),
    .sys_reset     (sys_reset),
    .ready         (ready),
    .loss_count    (loss_count),
    .timeout_count (timeout_count),
    .seq_state     (seq_state)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase number, cycles spent in it, and the two-sample lock delay line.
  int m_phase = 0;
  int m_since = 0;
  int m_loss  = 0;
  int m_tmo   = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  function automatic int bump(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc) return (c + 1 > CMAX) ? CMAX : c + 1;
    return c;
  endfunction

  task automatic model_step(input logic r, input logic lk, input logic clr);
    int n;
    int nxt;
    bit ls;
    bit linc;
    bit tinc;
    if (r) begin
      m_phase = 0; m_since = 0; m_s1 = 0; m_s2 = 0; m_loss = 0; m_tmo = 0;
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    n    = m_since + 1;
    nxt  = m_phase;
    linc = 0;
    tinc = 0;
    case (m_phase)
      0:       if (n >= P_RST) nxt = 1;
      1:       if (ls) nxt = 2; else if (n >= TMO) begin nxt = 0; tinc = 1; end
      2:       if (!ls) nxt = 1; else if (n >= STAB) nxt = 3;
      3:       if (!ls) begin nxt = 0; linc = 1; end else if (n >= REL) nxt = 4;
      default: if (!ls) begin nxt = 0; linc = 1; end
    endcase
    m_since = (nxt == m_phase) ? n : 0;
    m_phase = nxt;
    m_loss  = bump(m_loss, linc, clr);
    m_tmo   = bump(m_tmo, tinc, clr);
  endtask

  initial begin
    forever begin
      @(posedge refclk);
      model_step(rst, pll_locked, clear_count);
      @(negedge refclk);
      check("seq_state", 32'(seq_state), 32'(m_phase));
      check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
      check("sys_reset", 32'(sys_reset), 32'(m_phase != 4));
      check("ready", 32'(ready), 32'(m_phase == 4));
      check("loss_count", 32'(loss_count), 32'(m_loss));
      check("timeout_count", 32'(timeout_count), 32'(m_tmo));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the observation point right after the edge that sampled rst=1.
  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_sys_reset"}, 32'(sys_reset), 1);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_loss"}, 32'(loss_count), 0);
    check({tag, "_tmo"}, 32'(timeout_count), 0);
    check({tag, "_state"}, 32'(seq_state), 0);
  endtask

  // Drops lock for one cycle from RUN; effects must land on the 3rd edge.
  task automatic lose_lock(input bit clr, input int exp_loss);
    @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    check("loss_edge1_sys_reset", 32'(sys_reset), 0);
    @(negedge refclk);
    check("loss_edge2_sys_reset", 32'(sys_reset), 0);
    clear_count = clr;
    @(negedge refclk);
    clear_count = 1'b0;
    check("loss_edge3_sys_reset", 32'(sys_reset), 1);
    check("loss_edge3_pll_rst", 32'(pll_rst), 1);
    check("loss_edge3_ready", 32'(ready), 0);
    check("loss_edge3_loss_count", 32'(loss_count), 32'(exp_loss));
  endtask

  initial begin
    int hi;
    int first_rdy;
    int first_m;
    int first_rel;
    int rise1;
    int rise2;
    int lows;
    int prev;
    int tmo_at_504;
    int tmo_at_540;
    int waited;
    int run_left;

    // 1: clean lock
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    hi = 0; first_rdy = -1; first_m = -1;
    for (int e = 0; e <= 25; e++) begin
      if (e > 0) @(negedge refclk);
      if (e == 1) check("first_edge_after_rst_sys_reset", 32'(sys_reset), 1);
      if (pll_rst) hi++;
      if (ready && first_rdy < 0) first_rdy = e;
      if (m_phase == 4 && first_m < 0) first_m = e;
    end
    check("clean_pll_rst_width", 32'(hi), 4);
    check("clean_release_edge", 32'(first_rdy), 17);
    check("model_release_edge", 32'(first_m), 17);
    check("clean_loss_count", 32'(loss_count), 0);
    check("clean_timeout_count", 32'(timeout_count), 0);

    // 2: no lock at all
    pll_locked = 1'b0;
    do_reset();
    rise1 = -1; rise2 = -1; lows = 0; prev = 1; tmo_at_504 = -1; tmo_at_540 = -1;
    for (int e = 0; e <= 600; e++) begin
      if (e > 0) @(negedge refclk);
      if (pll_rst && prev == 0) begin
        if (rise1 < 0) rise1 = e;
        else if (rise2 < 0) rise2 = e;
      end
      prev = int'(pll_rst);
      if (!sys_reset) lows++;
      if (e == 504) tmo_at_504 = int'(timeout_count);
      if (e == 540) tmo_at_540 = int'(timeout_count);
    end
    check("timeout_first_repulse", 32'(rise1), 36);
    check("timeout_second_repulse", 32'(rise2), 72);
    check("timeout_sys_reset_never_low", 32'(lows), 0);
    check("timeout_count_14", 32'(tmo_at_504), 14);
    check("timeout_count_15", 32'(tmo_at_540), 15);
    check("timeout_count_saturated", 32'(timeout_count), 15);

    // 3: lock high 5 cycles, low 1, then high
    pll_locked = 1'b0;
    do_reset();
    first_rel = -1; first_rdy = -1;
    for (int e = 0; e <= 40; e++) begin
      if (e > 0) @(negedge refclk);
      if (seq_state == 3'd3 && first_rel < 0) first_rel = e;
      if (ready && first_rdy < 0) first_rdy = e;
      if (e == 5) pll_locked = 1'b1;
      if (e == 10) pll_locked = 1'b0;
      if (e == 11) pll_locked = 1'b1;
    end
    check("unstable_first_release", 32'(first_rel), 22);
    check("unstable_release_edge", 32'(first_rdy), 26);
    check("unstable_loss_count", 32'(loss_count), 0);

    // 4: loss in RUN, then relock
    lose_lock(1'b0, 1);
    repeat (18) @(negedge refclk);
    check("relock_ready", 32'(ready), 1);

    // 5: clear on the same edge as a loss increment
    lose_lock(1'b0, 2);
    repeat (18) @(negedge refclk);
    lose_lock(1'b0, 3);
    repeat (18) @(negedge refclk);
    check("pre_collision_loss", 32'(loss_count), 3);
    lose_lock(1'b1, 1);
    check("collision_timeout_count", 32'(timeout_count), 0);
    @(negedge refclk);
    clear_count = 1'b1;
    @(negedge refclk);
    clear_count = 1'b0;
    check("plain_clear_loss", 32'(loss_count), 0);

    // 6: reset while in RELEASE
    waited = 0;
    while (seq_state != 3'd3 && waited < 40) begin
      @(negedge refclk);
      waited++;
    end
    check("reached_release", 32'(seq_state), 3);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    check_reset_outputs("mid_release_rst");
    first_rdy = -1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge refclk);
      if (ready && first_rdy < 0) first_rdy = e;
    end
    check("restart_release_edge", 32'(first_rdy), 17);

    // Randomized lock runs, clears and occasional resets
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge refclk);
      if (run_left == 0) begin
        pll_locked = ($urandom_range(0, 2) != 0);
        run_left   = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
      end
      run_left--;
      clear_count = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 399) == 0);
    end
    @(negedge refclk);
    rst = 1'b0;
    clear_count = 1'b0;
    repeat (2) @(negedge refclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
